// File: rtl/atten_spi_if.sv
// Attenuator scheduler bus: gain capture inputs, config and SPI/status outputs.
// Master drives gain words and config; slave is the scheduler.
interface atten_spi_if #(
  parameter int NUM_CH     = 4,
  parameter int GAIN_WIDTH = 12
);
  logic [NUM_CH*GAIN_WIDTH-1:0] gain_word;
  logic [NUM_CH-1:0]            gain_valid;
  logic                         hold;
  logic                         cfg_enable;
  logic [GAIN_WIDTH-1:0]        cfg_deadband;
  logic                         spi_sclk;
  logic                         spi_cs_n;
  logic                         spi_mosi;
  logic                         busy;
  logic                         upd_done;
  logic [3:0]                   upd_ch;

  modport master (
    output gain_word, gain_valid, hold,
    output cfg_enable, cfg_deadband,
    input  spi_sclk, spi_cs_n, spi_mosi,
    input  busy, upd_done, upd_ch
  );

  modport slave (
    input  gain_word, gain_valid, hold,
    input  cfg_enable, cfg_deadband,
    output spi_sclk, spi_cs_n, spi_mosi,
    output busy, upd_done, upd_ch
  );
endinterface

// File: rtl/atten_spi_scheduler.sv
// Round-robin deadband scheduler writing per-channel gain words over SPI mode 0.
// Optional ATTEN_SPI_PARITY_EN appends an even-parity bit (17-bit frame).
module atten_spi_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int GAIN_WIDTH = 12,
  parameter int SCLK_DIV   = 4
) (
  input logic        clk,
  input logic        rst_n,
  atten_spi_if.slave bus
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW = $clog2(SCLK_DIV);
`ifdef ATTEN_SPI_PARITY_EN
  localparam int FW = 17;
`else
  localparam int FW = 16;
`endif

  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, GUARD
  } state_e;

  state_e                state_q;
  logic [DW-1:0]         div_q;
  logic [4:0]            bit_q;
  logic [FW-1:0]         sh_q;
  logic [GAIN_WIDTH-1:0] word_q [NUM_CH];
  logic [GAIN_WIDTH-1:0] sent_q [NUM_CH];
  logic [NUM_CH-1:0]     primed_q;
  logic [NUM_CH-1:0]     pend_q;
  logic [CW-1:0]         last_q;
  logic [CW-1:0]         gnt_q;
  logic                  sclk_q;
  logic                  cs_n_q;
  logic                  mosi_q;
  logic                  busy_q;
  logic                  done_q;
  logic [3:0]            ch_q;

  logic [GAIN_WIDTH-1:0] win [NUM_CH];
  logic                  found;
  logic [CW-1:0]         gnt;
  logic [CW-1:0]         idx;
  logic                  start;
  logic                  div_last;
  logic [15:0]           f16;
  logic [FW-1:0]         frame;

  function automatic logic exceeds(
    input logic [GAIN_WIDTH-1:0] a,
    input logic [GAIN_WIDTH-1:0] b,
    input logic [GAIN_WIDTH-1:0] d
  );
    logic [GAIN_WIDTH:0] diff;
    if (a >= b) diff = {1'b0, a} - {1'b0, b};
    else        diff = {1'b0, b} - {1'b0, a};
    return diff > {1'b0, d};
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      win[k] = bus.gain_word[k*GAIN_WIDTH +: GAIN_WIDTH];
  end

  // First pending channel after the last grant, wrapping
  always_comb begin
    found = 1'b0;
    gnt   = last_q;
    idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CW'((int'(last_q) + i) % NUM_CH);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign start = (state_q == IDLE) && bus.cfg_enable
              && !bus.hold && found;
  assign div_last = (div_q == DW'(SCLK_DIV - 1));
  assign f16 = {4'(gnt), 12'(word_q[gnt])};

`ifdef ATTEN_SPI_PARITY_EN
  assign frame = {f16, ^f16};
`else
  assign frame = f16;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      primed_q <= '0;
      pend_q   <= '0;
      last_q   <= CW'(NUM_CH - 1);
      gnt_q    <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ch_q     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        word_q[k] <= '0;
        sent_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      // Same-cycle capture on a granted channel compares to the snapshot
      for (int k = 0; k < NUM_CH; k++) begin
        if (start && gnt == CW'(k)) begin
          sent_q[k]   <= word_q[k];
          primed_q[k] <= 1'b1;
          pend_q[k]   <= bus.gain_valid[k]
                      && exceeds(win[k], word_q[k], bus.cfg_deadband);
        end else if (bus.gain_valid[k]
                  && (!primed_q[k]
                  || exceeds(win[k], sent_q[k], bus.cfg_deadband))) begin
          pend_q[k] <= 1'b1;
        end
        if (bus.gain_valid[k]) word_q[k] <= win[k];
      end

      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            last_q  <= gnt;
            gnt_q   <= gnt;
            sh_q    <= frame;
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= frame[FW-1];
            busy_q  <= 1'b1;
            div_q   <= '0;
          end
        end
        LOAD: begin
          div_q <= div_q + 1'b1;
          if (div_last) begin
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          div_q <= div_q + 1'b1;
          if (div_last) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (bit_q == 5'(FW - 1)) begin
              state_q <= GUARD;
              sclk_q  <= 1'b0;
              cs_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
            end else begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 1'b1;
              sh_q   <= {sh_q[FW-2:0], 1'b0};
              mosi_q <= sh_q[FW-2];
            end
          end
        end
        GUARD: begin
          div_q <= div_q + 1'b1;
          if (div_last) begin
            div_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ch_q    <= 4'(gnt_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.spi_sclk = sclk_q;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.upd_done = done_q;
  assign bus.upd_ch   = ch_q;

endmodule

// File: tb/tb_atten_spi_scheduler.sv
// Directed bench for atten_spi_scheduler: frame content, timing,
// deadband, round-robin, hold/enable and reset abort.
module tb_atten_spi_scheduler;

`ifdef ATTEN_SPI_PARITY_EN
  localparam int FW = 17;
`else
  localparam int FW = 16;
`endif
  localparam int D      = 4;
  localparam int CSLOW  = (2*FW + 1) * D;
  localparam int BUSYC  = (2*FW + 2) * D;
  localparam int PERIOD = BUSYC + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  atten_spi_if #(.NUM_CH(4), .GAIN_WIDTH(12)) ifc ();

  atten_spi_scheduler #(
    .NUM_CH(4), .GAIN_WIDTH(12), .SCLK_DIV(D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #2.5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] fr_q[$];
  int          nb_q[$];
  int          cs_q[$];
  int          bz_q[$];
  int          br_q[$];
  logic [3:0]  up_q[$];

  logic [31:0] acc;
  int nb, cslow, bsy, cyc;
  logic sclk_p, cs_p, busy_p;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      acc = 0; nb = 0; cslow = 0; bsy = 0;
      sclk_p = 0; cs_p = 1; busy_p = 0;
    end else begin
      if (!ifc.spi_cs_n) cslow++;
      if (ifc.busy) bsy++;
      if (ifc.busy && !busy_p) br_q.push_back(cyc);
      if (ifc.spi_sclk && !sclk_p && !ifc.spi_cs_n) begin
        acc = {acc[30:0], ifc.spi_mosi};
        nb++;
      end
      if (ifc.spi_cs_n && !cs_p) begin
        fr_q.push_back(acc);
        nb_q.push_back(nb);
        cs_q.push_back(cslow);
        acc = 0; nb = 0; cslow = 0;
      end
      if (!ifc.busy && busy_p) begin
        bz_q.push_back(bsy);
        bsy = 0;
      end
      if (ifc.upd_done) up_q.push_back(ifc.upd_ch);
      sclk_p = ifc.spi_sclk;
      cs_p   = ifc.spi_cs_n;
      busy_p = ifc.busy;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fx(input logic [15:0] f);
`ifdef ATTEN_SPI_PARITY_EN
    return {15'd0, f, ^f};
`else
    return {16'd0, f};
`endif
  endfunction

  task automatic pulse(input int ch, input logic [11:0] w);
    @(negedge clk);
    ifc.gain_word[ch*12 +: 12] = w;
    ifc.gain_valid = 4'(1 << ch);
    @(negedge clk);
    ifc.gain_valid = '0;
  endtask

  // Checks the next frame (index f) fully: data, length, timing, channel
  task automatic chk_frame(input string nm, input int f, input int u,
                           input int b, input logic [15:0] exp,
                           input int ch);
    if (fr_q.size() > f) begin
      chk({nm, "_data"}, fr_q[f], fx(exp));
      chk({nm, "_bits"}, nb_q[f], FW);
      chk({nm, "_cslow"}, cs_q[f], CSLOW);
    end
    if (bz_q.size() > b) chk({nm, "_busy"}, bz_q[b], BUSYC);
    if (up_q.size() > u) chk({nm, "_updch"}, up_q[u], ch);
  endtask

  typedef struct {
    int          ch;
    logic [11:0] word;
    logic [11:0] db;
    bit          fr;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[10];

  initial begin
    int f0, u0, b0, r0, waitc;

    vt[0] = '{2, 12'h3A5, 12'd8,   1'b1, 16'h23A5};
    vt[1] = '{1, 12'h100, 12'd8,   1'b1, 16'h1100};
    vt[2] = '{1, 12'h105, 12'd8,   1'b0, 16'h0000};
    vt[3] = '{1, 12'h109, 12'd8,   1'b1, 16'h1109};
    vt[4] = '{1, 12'h101, 12'd8,   1'b0, 16'h0000};
    vt[5] = '{1, 12'h100, 12'd8,   1'b1, 16'h1100};
    vt[6] = '{3, 12'hFFF, 12'd0,   1'b1, 16'h3FFF};
    vt[7] = '{3, 12'hFFF, 12'd0,   1'b0, 16'h0000};
    vt[8] = '{3, 12'h000, 12'hFFE, 1'b1, 16'h3000};
    vt[9] = '{0, 12'h5A5, 12'd0,   1'b1, 16'h05A5};

    ifc.gain_word    = '0;
    ifc.gain_valid   = '0;
    ifc.hold         = 1'b0;
    ifc.cfg_enable   = 1'b1;
    ifc.cfg_deadband = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", ifc.spi_sclk, 0);
    chk("rst_cs_n", ifc.spi_cs_n, 1);
    chk("rst_mosi", ifc.spi_mosi, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.upd_done, 0);
    chk("rst_updch", ifc.upd_ch, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      f0 = fr_q.size(); u0 = up_q.size(); b0 = bz_q.size();
      ifc.cfg_deadband = vt[i].db;
      pulse(vt[i].ch, vt[i].word);
      repeat (PERIOD + 25) @(negedge clk);
      chk($sformatf("v%0d_count", i), fr_q.size() - f0, vt[i].fr);
      chk($sformatf("v%0d_upds", i), up_q.size() - u0, vt[i].fr);
      if (vt[i].fr)
        chk_frame($sformatf("v%0d", i), f0, u0, b0, vt[i].exp, vt[i].ch);
    end
    chk("idle_mosi", ifc.spi_mosi, 0);

    // Round robin from last grant 0: expect 1, 3, 0 back-to-back
    f0 = fr_q.size(); u0 = up_q.size(); b0 = bz_q.size();
    r0 = br_q.size();
    @(negedge clk);
    ifc.cfg_deadband = '0;
    ifc.gain_word[0 +: 12]  = 12'h0AA;
    ifc.gain_word[12 +: 12] = 12'h1F0;
    ifc.gain_word[36 +: 12] = 12'h333;
    ifc.gain_valid = 4'b1011;
    @(negedge clk);
    ifc.gain_valid = '0;
    repeat (3*PERIOD + 25) @(negedge clk);
    chk("rr_count", fr_q.size() - f0, 3);
    chk_frame("rr0", f0,     u0,     b0,     16'h11F0, 1);
    chk_frame("rr1", f0 + 1, u0 + 1, b0 + 1, 16'h3333, 3);
    chk_frame("rr2", f0 + 2, u0 + 2, b0 + 2, 16'h00AA, 0);
    if (br_q.size() >= r0 + 3) begin
      chk("rr_gap1", br_q[r0+1] - br_q[r0], PERIOD);
      chk("rr_gap2", br_q[r0+2] - br_q[r0+1], PERIOD);
    end else begin
      chk("rr_starts", br_q.size() - r0, 3);
    end

    // Hold blocks start, release starts at once, mid-frame hold ignored
    f0 = fr_q.size(); u0 = up_q.size(); b0 = bz_q.size();
    ifc.hold = 1'b1;
    pulse(0, 12'h7FF);
    repeat (200) @(negedge clk);
    chk("hold_block", fr_q.size() - f0, 0);
    chk("hold_busy", ifc.busy, 0);
    ifc.hold = 1'b0;
    @(negedge clk);
    chk("hold_release", ifc.busy, 1);
    repeat (40) @(negedge clk);
    ifc.hold = 1'b1;
    repeat (150) @(negedge clk);
    chk("hold_mid_count", fr_q.size() - f0, 1);
    chk_frame("hold_mid", f0, u0, b0, 16'h07FF, 0);

    // Enable low blocks start, pending retained
    f0 = fr_q.size(); u0 = up_q.size(); b0 = bz_q.size();
    pulse(2, 12'h000);
    repeat (200) @(negedge clk);
    ifc.cfg_enable = 1'b0;
    ifc.hold = 1'b0;
    repeat (200) @(negedge clk);
    chk("en_block", fr_q.size() - f0, 0);
    ifc.cfg_enable = 1'b1;
    repeat (PERIOD + 25) @(negedge clk);
    chk("en_count", fr_q.size() - f0, 1);
    chk_frame("en", f0, u0, b0, 16'h2000, 2);

    // Reset during SHIFT bit 7 aborts and clears state
    pulse(3, 12'h444);
    waitc = 0;
    while (!ifc.busy && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("rst_frame_started", ifc.busy, 1);
    pulse(2, 12'h555);
    repeat (64) @(negedge clk);
    u0 = up_q.size();
    #2;
    rst_n = 1'b0;
    #0.5;
    chk("abort_cs_n", ifc.spi_cs_n, 1);
    chk("abort_sclk", ifc.spi_sclk, 0);
    chk("abort_busy", ifc.busy, 0);
    chk("abort_done", ifc.upd_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = fr_q.size(); b0 = bz_q.size();
    repeat (200) @(negedge clk);
    chk("abort_no_upd", up_q.size() - u0, 0);
    chk("abort_no_pend", fr_q.size() - f0, 0);

    // Unprimed after reset: same words still send, order from ch0
    ifc.cfg_deadband = 12'hFFF;
    @(negedge clk);
    ifc.gain_word[0 +: 12]  = 12'h7FF;
    ifc.gain_word[12 +: 12] = 12'h1F0;
    ifc.gain_valid = 4'b0011;
    @(negedge clk);
    ifc.gain_valid = '0;
    repeat (2*PERIOD + 25) @(negedge clk);
    chk("post_rst_count", fr_q.size() - f0, 2);
    chk_frame("post_rst0", f0,     u0,     b0,     16'h07FF, 0);
    chk_frame("post_rst1", f0 + 1, u0 + 1, b0 + 1, 16'h11F0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
